// File: rtl/usb_link_arbiter.sv
// usb_link_arbiter
// Half-duplex ownership controller for the shared USB D+/D- line.
// It hands the line to either the receive path or the transmit engine.
// It inserts turnaround gaps between packets and watches the reply window
// after a transmit that expects an answer.
//
// TX handshake: the TX engine raises tx_req and holds it high. The engine may
// drive data only while tx_grant is high. The transfer ends when tx_done
// pulses for one cycle. Dropping tx_req while granted and without tx_done
// aborts the transfer. tx_grant never rises in the cycle right after
// tx_req; it rises two cycles later, after the driver-settle cycle.
module usb_link_arbiter #(
  parameter int IPD_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic Reset,
  input  logic rx_active,
  input  logic rx_frame_complete,
  input  logic rx_error,
  input  logic tx_req,
  input  logic tx_done,
  input  logic expect_reply,
  output logic oe,
  output logic tx_grant,
  output logic rx_enable,
  output logic bus_busy,
  output logic timeout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_BUSY    = 3'd1,
    S_RX_GAP     = 3'd2,
    S_TX_ARM     = 3'd3,
    S_TX_ACTIVE  = 3'd4,
    S_TX_GAP     = 3'd5,
    S_WAIT_REPLY = 3'd6
  } state_t;

  // The counter is loaded with length-1 so that the last cycle of a window
  // is the one where it reads zero.
  localparam logic [CNT_W-1:0] IPD_LOAD = CNT_W'(IPD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             reply_pend;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // State, shared gap/reply counter, pending-reply flag and timeout pulse.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      reply_pend <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          // Receive wins a same-cycle collision: the line is already busy.
          if (rx_active) begin
            state <= S_RX_BUSY;
          end else if (tx_req) begin
            state <= S_TX_ARM;
          end
        end
        S_RX_BUSY: begin
          if (rx_frame_complete || rx_error) begin
            state <= S_RX_GAP;
            cnt   <= IPD_LOAD;
          end
        end
        S_RX_GAP: begin
          // A back-to-back packet abandons the remaining gap.
          if (rx_active) begin
            state <= S_RX_BUSY;
          end else if (cnt_zero) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_TX_ARM: begin
          state <= S_TX_ACTIVE;
        end
        S_TX_ACTIVE: begin
          // tx_done takes precedence over a simultaneous drop of tx_req.
          if (tx_done) begin
            state      <= S_TX_GAP;
            cnt        <= IPD_LOAD;
            reply_pend <= expect_reply;
          end else if (!tx_req) begin
            state      <= S_TX_GAP;
            cnt        <= IPD_LOAD;
            reply_pend <= 1'b0;
          end
        end
        S_TX_GAP: begin
          if (cnt_zero) begin
            reply_pend <= 1'b0;
            if (reply_pend) begin
              state <= S_WAIT_REPLY;
              cnt   <= TO_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_REPLY: begin
          // A reply starting in the final window cycle still counts.
          if (rx_active) begin
            state <= S_RX_BUSY;
          end else if (cnt_zero) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          reply_pend <= 1'b0;
        end
      endcase
    end
  end

  // PHY and TX controls are decoded from the state register alone.
  always_comb begin
    oe        = 1'b0;
    tx_grant  = 1'b0;
    rx_enable = 1'b0;
    bus_busy  = 1'b1;
    case (state)
      S_IDLE: begin
        rx_enable = 1'b1;
        bus_busy  = 1'b0;
      end
      S_RX_BUSY, S_RX_GAP, S_WAIT_REPLY: begin
        rx_enable = 1'b1;
      end
      S_TX_ARM: begin
        oe = 1'b1;
      end
      S_TX_ACTIVE: begin
        oe       = 1'b1;
        tx_grant = 1'b1;
      end
      S_TX_GAP: begin
        // Line turnaround: neither side listens nor drives.
      end
      default: begin
        rx_enable = 1'b1;
        bus_busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_link_arbiter.sv
// Bench for usb_link_arbiter: a vector table, hand-written multi-cycle
// sequences, and a randomized run against a timestamp-based reference model.
module tb_usb_link_arbiter;

  localparam int IPD = 8;
  localparam int TO  = 200;

  // Input vector packing: {rx_active, rx_frame_complete, rx_error, tx_req, tx_done, expect_reply}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RA   = 6'b100000;
  localparam logic [5:0] I_FC   = 6'b010000;
  localparam logic [5:0] I_TR   = 6'b000100;
  localparam logic [5:0] I_TD   = 6'b000010;
  localparam logic [5:0] I_EX   = 6'b000001;

  // Output vector packing: {oe, tx_grant, rx_enable, bus_busy, timeout}
  localparam logic [4:0] O_IDLE  = 5'b00100;
  localparam logic [4:0] O_RX    = 5'b00110;
  localparam logic [4:0] O_ARM   = 5'b10010;
  localparam logic [4:0] O_ACT   = 5'b11010;
  localparam logic [4:0] O_TXGAP = 5'b00010;
  localparam logic [4:0] O_TOUT  = 5'b00101;

  logic clk, Reset;
  logic rx_active, rx_frame_complete, rx_error, tx_req, tx_done, expect_reply;
  logic oe, tx_grant, rx_enable, bus_busy, timeout;
  logic [4:0] outs;

  int pass_cnt  = 0;
  int check_cnt = 0;

  typedef struct {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];

  usb_link_arbiter #(.IPD_CYCLES(IPD), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .Reset(Reset),
    .rx_active(rx_active), .rx_frame_complete(rx_frame_complete),
    .rx_error(rx_error), .tx_req(tx_req), .tx_done(tx_done),
    .expect_reply(expect_reply),
    .oe(oe), .tx_grant(tx_grant), .rx_enable(rx_enable),
    .bus_busy(bus_busy), .timeout(timeout)
  );

  assign outs = {oe, tx_grant, rx_enable, bus_busy, timeout};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (oe,grant,rx_en,busy,timeout) at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [5:0] in);
    {rx_active, rx_frame_complete, rx_error, tx_req, tx_done, expect_reply} = in;
  endtask

  // One clock cycle: drive inputs, check the current outputs on the falling edge, then advance.
  task automatic cyc(input string name, input logic [5:0] in, input logic [4:0] exp);
    drive(in);
    @(negedge clk);
    check(name, outs, exp);
    @(posedge clk);
    #1;
  endtask

  // Reference model: modes with absolute-time deadlines.
  localparam int M_IDLE = 0, M_RX = 1, M_RXGAP = 2, M_ARM = 3, M_TX = 4, M_TXGAP = 5, M_WAIT = 6;
  int   m_mode;
  int   m_deadline;
  int   m_t;
  logic m_pend;
  logic m_to;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_deadline = 0;
    m_pend = 1'b0;
    m_to = 1'b0;
  endtask

  function automatic logic [4:0] model_out();
    logic [4:0] v;
    case (m_mode)
      M_IDLE:  v = O_IDLE;
      M_ARM:   v = O_ARM;
      M_TX:    v = O_ACT;
      M_TXGAP: v = O_TXGAP;
      default: v = O_RX;
    endcase
    return v | {4'b0, m_to};
  endfunction

  task automatic model_step(input logic [5:0] in);
    logic ra, fc, er, tr, td, ex;
    {ra, fc, er, tr, td, ex} = in;
    m_to = 1'b0;
    case (m_mode)
      M_IDLE:  if (ra) m_mode = M_RX; else if (tr) m_mode = M_ARM;
      M_RX:    if (fc || er) begin m_mode = M_RXGAP; m_deadline = m_t + IPD; end
      M_RXGAP: if (ra) m_mode = M_RX; else if (m_t == m_deadline) m_mode = M_IDLE;
      M_ARM:   m_mode = M_TX;
      M_TX: begin
        if (td) begin m_mode = M_TXGAP; m_pend = ex; m_deadline = m_t + IPD; end
        else if (!tr) begin m_mode = M_TXGAP; m_pend = 1'b0; m_deadline = m_t + IPD; end
      end
      M_TXGAP: if (m_t == m_deadline) begin
        if (m_pend) begin m_mode = M_WAIT; m_deadline = m_t + TO; end
        else m_mode = M_IDLE;
      end
      M_WAIT: begin
        if (ra) m_mode = M_RX;
        else if (m_t == m_deadline) begin m_mode = M_IDLE; m_to = 1'b1; end
      end
      default: m_mode = M_IDLE;
    endcase
    m_t++;
  endtask

  initial begin
    // Reset
    Reset = 1'b1;
    drive(I_NONE);
    @(negedge clk);
    check("reset_outputs", outs, O_IDLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Vector table: basic TX with no reply, then collision and abort.
    for (int i = 0; i < 5; i++) tbl.push_back('{I_NONE, O_IDLE});
    tbl.push_back('{I_TR, O_IDLE});
    tbl.push_back('{I_TR, O_ARM});
    for (int i = 0; i < 5; i++) tbl.push_back('{I_TR, O_ACT});
    tbl.push_back('{I_TR | I_TD, O_ACT});
    for (int i = 0; i < IPD; i++) tbl.push_back('{I_NONE, O_TXGAP});
    tbl.push_back('{I_NONE, O_IDLE});
    tbl.push_back('{I_RA | I_TR, O_IDLE});
    tbl.push_back('{I_RA | I_TR, O_RX});
    tbl.push_back('{I_FC | I_TR, O_RX});
    for (int i = 0; i < IPD; i++) tbl.push_back('{I_TR, O_RX});
    tbl.push_back('{I_TR, O_IDLE});
    tbl.push_back('{I_TR, O_ARM});
    tbl.push_back('{I_NONE, O_ACT});
    for (int i = 0; i < IPD; i++) tbl.push_back('{I_NONE, O_TXGAP});
    tbl.push_back('{I_NONE, O_IDLE});
    tbl.push_back('{I_NONE, O_IDLE});
    foreach (tbl[i]) cyc($sformatf("vec[%0d]", i), tbl[i].in, tbl[i].exp);

    // Reply timeout: single pulse after the full window, no grant.
    cyc("to_req", I_TR, O_IDLE);
    cyc("to_arm", I_TR, O_ARM);
    cyc("to_done", I_TR | I_TD | I_EX, O_ACT);
    for (int i = 0; i < IPD; i++) cyc("to_gap", I_NONE, O_TXGAP);
    for (int i = 0; i < TO; i++) cyc("to_wait", I_NONE, O_RX);
    cyc("to_pulse", I_NONE, O_TOUT);
    cyc("to_after", I_NONE, O_IDLE);

    // Reply received at window cycle 50: no timeout.
    cyc("rp_req", I_TR, O_IDLE);
    cyc("rp_arm", I_TR, O_ARM);
    cyc("rp_done", I_TD | I_EX, O_ACT);
    for (int i = 0; i < IPD; i++) cyc("rp_gap", I_NONE, O_TXGAP);
    for (int i = 0; i < 50; i++) cyc("rp_wait", I_NONE, O_RX);
    cyc("rp_sync", I_RA, O_RX);
    for (int i = 0; i < 5; i++) cyc("rp_busy", I_RA, O_RX);
    cyc("rp_eop", I_FC, O_RX);
    for (int i = 0; i < IPD; i++) cyc("rp_rxgap", I_NONE, O_RX);
    for (int i = 0; i < TO; i++) cyc("rp_idle", I_NONE, O_IDLE);

    // Reply in the last window cycle takes priority over the timeout.
    cyc("lw_req", I_TR, O_IDLE);
    cyc("lw_arm", I_TR, O_ARM);
    cyc("lw_done", I_TD | I_EX, O_ACT);
    for (int i = 0; i < IPD; i++) cyc("lw_gap", I_NONE, O_TXGAP);
    for (int i = 0; i < TO - 1; i++) cyc("lw_wait", I_NONE, O_RX);
    cyc("lw_last", I_RA, O_RX);
    cyc("lw_busy", I_RA, O_RX);
    cyc("lw_err", I_RA | 6'b001000, O_RX);
    for (int i = 0; i < IPD; i++) cyc("lw_rxgap", I_NONE, O_RX);
    cyc("lw_idle", I_NONE, O_IDLE);

    // Reset mid-TX_ACTIVE drops oe and tx_grant at once.
    cyc("rt_req", I_TR, O_IDLE);
    cyc("rt_arm", I_TR, O_ARM);
    cyc("rt_act", I_TR, O_ACT);
    Reset = 1'b1;
    #1;
    check("rt_async_drop", outs, O_IDLE);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    cyc("rt_post", I_NONE, O_IDLE);
    cyc("rt_req2", I_TR, O_IDLE);
    cyc("rt_arm2", I_TR, O_ARM);
    cyc("rt_act2", I_TR | I_TD, O_ACT);
    for (int i = 0; i < IPD; i++) cyc("rt_gap2", I_NONE, O_TXGAP);
    cyc("rt_idle2", I_NONE, O_IDLE);

    // Reset mid-WAIT_REPLY: no timeout pulse afterwards.
    cyc("rw_req", I_TR, O_IDLE);
    cyc("rw_arm", I_TR, O_ARM);
    cyc("rw_done", I_TD | I_EX, O_ACT);
    for (int i = 0; i < IPD; i++) cyc("rw_gap", I_NONE, O_TXGAP);
    for (int i = 0; i < 20; i++) cyc("rw_wait", I_NONE, O_RX);
    Reset = 1'b1;
    #1;
    check("rw_async", outs, O_IDLE);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < TO + 20; i++) cyc("rw_no_timeout", I_NONE, O_IDLE);

    // Randomized run against the reference model.
    Reset = 1'b1;
    model_reset();
    m_t = 0;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    begin
      logic tr_hold;
      logic [5:0] in;
      int ra_den;
      tr_hold = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        ra_den = ((n / 1000) % 2 == 0) ? 8 : 400;
        if ($urandom_range(0, 9) == 0) tr_hold = ~tr_hold;
        in = {($urandom_range(1, ra_den) == 1) ? 1'b1 : 1'b0,
              ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              tr_hold,
              ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1))};
        drive(in);
        if ($urandom_range(0, 299) == 0) begin
          Reset = 1'b1;
          model_reset();
          @(negedge clk);
          check($sformatf("rand_reset[%0d]", n), outs, model_out());
          @(posedge clk);
          #1;
          Reset = 1'b0;
        end else begin
          @(negedge clk);
          check($sformatf("rand[%0d]", n), outs, model_out());
          model_step(in);
          @(posedge clk);
          #1;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/usb_link_arbiter.md
# usb_link_arbiter

Half-duplex bus-ownership controller for the USB transceiver. It sequences the shared D+/D- line between the receive FSM and the transmit engine. It enforces inter-packet turnaround gaps and times out when an expected reply never arrives. It sits between the protocol layer (TX requests) and the PHY (driver output enable, receiver enable).

## Interface
Parameters:
- IPD_CYCLES, 8, inter-packet/turnaround gap length in clk cycles; must be ≥1 and < 2**CNT_W
- TIMEOUT_CYCLES, 200, reply-wait window in clk cycles; must be ≥1 and < 2**CNT_W
- CNT_W, 8, width of the shared down-counter

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- rx_active  in  1  receive FSM reports a packet in progress (SYNC seen)
- rx_frame_complete  in  1  one-cycle pulse: RX frame terminated cleanly
- rx_error  in  1  RX error flag (any cycle high counts)
- tx_req  in  1  TX engine requests the bus; held high until tx_done or abort
- tx_done  in  1  one-cycle pulse: TX EOP finished
- expect_reply  in  1  sampled with tx_done: a reply packet is expected
- oe  out  1  line-driver output enable
- tx_grant  out  1  TX engine may drive data
- rx_enable  out  1  receiver enabled
- bus_busy  out  1  bus owned or in a gap (any state but IDLE)
- timeout  out  1  one-cycle pulse: reply window expired

## Operation
- Moore machine: outputs decode from the state register only, except timeout, which is a registered flag. No input-to-output combinational path.
- States and outputs:
  - IDLE: rx_enable=1.
  - RX_BUSY: rx_enable=1, bus_busy=1.
  - RX_GAP: rx_enable=1, bus_busy=1.
  - TX_ARM: oe=1, bus_busy=1.
  - TX_ACTIVE: oe=1, tx_grant=1, bus_busy=1.
  - TX_GAP: bus_busy=1; oe=0 and rx_enable=0 (line turnaround).
  - WAIT_REPLY: rx_enable=1, bus_busy=1.
- Transitions:
  - IDLE: rx_active → RX_BUSY. Else tx_req → TX_ARM. rx_active wins when both are high in the same cycle.
  - RX_BUSY: rx_frame_complete or rx_error → RX_GAP. Otherwise hold; tx_req is ignored.
  - RX_GAP: rx_active → RX_BUSY (back-to-back packet, counter discarded). Counter==0 → IDLE.
  - TX_ARM: unconditional → TX_ACTIVE (one cycle of driver settle).
  - TX_ACTIVE: tx_done → TX_GAP, capturing expect_reply into reply_pend. tx_req low without tx_done is an abort → TX_GAP with reply_pend=0. tx_done and tx_req fall in the same cycle counts as normal completion.
  - TX_GAP: counter==0 → WAIT_REPLY if reply_pend, else IDLE. RX inputs are ignored.
  - WAIT_REPLY: rx_active → RX_BUSY, which clears the window with no timeout. Counter==0 → IDLE and set timeout for one cycle. tx_req is ignored.
- Counter:
  - CNT_W bits, single shared counter.
  - Loaded with IPD_CYCLES-1 on entry to RX_GAP or TX_GAP.
  - Loaded with TIMEOUT_CYCLES-1 on entry to WAIT_REPLY.
  - Decrements each cycle while in those states. No wrap: a state exits at 0, so the counter never underflows.
- Reset:
  - Async reset forces IDLE, counter=0, reply_pend=0, timeout=0.
  - Reset values: oe=0, tx_grant=0, rx_enable=1, bus_busy=0, timeout=0.
  - Reset mid-TX drops oe and tx_grant immediately, asynchronously via the state register.
- Illegal state encodings → IDLE next cycle.

## Timing
- tx_req high at edge N while in IDLE:
  - oe=1 from N+1.
  - tx_grant=1 from N+2.
  - Grant latency is 2 cycles.
- tx_done at edge M: oe and tx_grant low from M+1.
- TX_GAP occupies exactly IPD_CYCLES cycles. RX_GAP occupies the same unless interrupted by rx_active.
- WAIT_REPLY occupies exactly TIMEOUT_CYCLES cycles if no rx_active arrives. timeout is high in the first IDLE cycle after that and low the next.
- rx_active in the last WAIT_REPLY cycle (counter==0) takes priority: → RX_BUSY, no timeout.
- Earliest re-grant after a TX with no reply: tx_done at M, IDLE at M+IPD_CYCLES+1, tx_grant at M+IPD_CYCLES+3.

## Test plan
- Reset, then tx_req high at cycle 5, tx_done at cycle 12 with expect_reply=0:
  - oe=1 at 6, tx_grant=1 at 7.
  - Both low at 13.
  - bus_busy low at 13+8=21; IDLE.
- Reply timeout (IPD=8, TIMEOUT=200): tx_done with expect_reply=1, no rx_active:
  - rx_enable=0 for 8 cycles, then 1.
  - timeout is a single pulse exactly 208 cycles after tx_done+1.
  - tx_grant stays 0 throughout.
- Reply received: as above, with rx_active at reply-window cycle 50, then rx_frame_complete:
  - RX_BUSY entered, no timeout pulse.
  - RX_GAP lasts 8 cycles, then IDLE.
- Collision and abort:
  - rx_active and tx_req both high in IDLE → RX_BUSY, oe stays 0. tx_grant is given only after RX_GAP ends, 2 cycles later.
  - tx_req dropped in TX_ACTIVE without tx_done → TX_GAP, then IDLE with no WAIT_REPLY.
- Reset asserted mid-TX_ACTIVE and mid-WAIT_REPLY:
  - oe and tx_grant drop in the same cycle; rx_enable=1.
  - No timeout pulse.
  - After release, the next tx_req shows the full 2-cycle grant latency.
